// File: rtl/mul32_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encodings and default sizing constants.
package mul32_seq_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul32_seq_if.sv
// Request/response bundle of the multiplier: operands and start in,
// busy/done/product out.
interface mul32_seq_if
    import mul32_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic               start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] P;

    modport master (output start, A, B, input busy, done, P);
    modport slave  (input start, A, B, output busy, done, P);
endinterface

// File: rtl/mul32_seq_add.sv
// Add-with-carry adder: S = A + B + C0 with the carry kept in S[WIDTH].
module mul32_seq_add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c0,
    output logic [WIDTH:0]   o_s
);

    assign o_s = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_c0};

endmodule

// File: rtl/mul32_seq.sv
// Iterative unsigned shift-add multiplier: one partial-product accumulate per
// cycle through the shared adder, 2*WIDTH-bit product after WIDTH iterations.
module mul32_seq
    import mul32_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    mul32_seq_if.slave  bus
);

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_p;

    state_t               w_state_nxt;
    logic [WIDTH-1:0]     w_mcand_nxt;
    logic [WIDTH-1:0]     w_hi_nxt;
    logic [WIDTH-1:0]     w_lo_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic [2*WIDTH-1:0]   w_p_nxt;

    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;

    // The carry out of the accumulate lands in hi's MSB after the shift.
    assign w_addend = r_lo[0] ? r_mcand : {WIDTH{1'b0}};

    mul32_seq_add #(.WIDTH(WIDTH)) u_add (
        .i_a  (r_hi),
        .i_b  (w_addend),
        .i_c0 (1'b0),
        .o_s  (w_sum)
    );

    // Next-state and next-value decode for the FSM and datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_mcand_nxt = r_mcand;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_p_nxt     = r_p;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_mcand_nxt = bus.A;
                    w_hi_nxt    = {WIDTH{1'b0}};
                    w_lo_nxt    = bus.B;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_state_nxt = S_RUN;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                w_hi_nxt  = w_sum[WIDTH:1];
                w_lo_nxt  = {w_sum[0], r_lo[WIDTH-1:1]};
                w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                if (r_cnt == CNT_W'(WIDTH-1)) begin
                    w_p_nxt     = {w_sum, r_lo[WIDTH-1:1]};
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mcand <= {WIDTH{1'b0}};
            r_hi    <= {WIDTH{1'b0}};
            r_lo    <= {WIDTH{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_p     <= {(2*WIDTH){1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_mcand <= w_mcand_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_p     <= w_p_nxt;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.P    = r_p;

endmodule
